// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default word size and
// the line levels used on the serial wire.
package uart_pkg;

    localparam int DEFAULT_MAX_WORD_SIZE = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_STOP  = 1'b1;
    localparam logic LINE_START = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GUARD
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word buffer in front of the serializer. The head word is visible
// combinationally so the FSM can load it on the same edge that pops it.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so plain pointer increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by the
    // pointers and level, so clearing the array would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: one bit per clock, start/data/stop/guard framing,
// with the word length chosen per frame from tx_bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int MAX_WORD_SIZE = DEFAULT_MAX_WORD_SIZE,
    parameter int FIFO_DEPTH    = 4,
    parameter int GUARD_CYCLES  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [MAX_WORD_SIZE-1:0]    din,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic [5:0]                  tx_bits,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CNT_W = $clog2(MAX_WORD_SIZE + 1);
    localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    tx_state_t                state;
    logic [MAX_WORD_SIZE-1:0] shift_reg;
    logic [CNT_W-1:0]         n_bits;
    logic [CNT_W-1:0]         bit_cnt;
    logic [GRD_W-1:0]         guard_cnt;
    logic                     guard_last;
    logic                     accept_en;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [MAX_WORD_SIZE-1:0] fifo_head;
    logic                     load;

    // Out-of-range requests fall back to the widest frame the datapath holds.
    function automatic logic [CNT_W-1:0] frame_bits(input logic [5:0] req);
        if (req == 6'd0 || int'(req) > MAX_WORD_SIZE) return CNT_W'(MAX_WORD_SIZE);
        return CNT_W'(req);
    endfunction

    assign guard_last = (guard_cnt == GRD_W'(GUARD_CYCLES - 1));
    assign load       = !fifo_empty && ((state == IDLE) || (state == GUARD && guard_last));
    assign din_ready  = accept_en && !fifo_full;

    uart_tx_fifo #(
        .WIDTH (MAX_WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (din_valid && din_ready),
        .push_data (din),
        .pop       (load),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Holds din_ready low through reset and opens it on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) accept_en <= 1'b0;
        else        accept_en <= 1'b1;
    end

    // NOTE: every assignment here is non-blocking so the state, counters and
    // registered outputs all update together from the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            n_bits    <= CNT_W'(MAX_WORD_SIZE);
            bit_cnt   <= '0;
            guard_cnt <= '0;
            tx        <= LINE_IDLE;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // Outputs are registered from the current state, so the line trails
            // the state by one cycle; this gives the two-edge push-to-start latency.
            tx_busy <= (state != IDLE);
            tx_done <= (state == GUARD) && (guard_cnt == '0);

            unique case (state)
                IDLE: begin
                    tx <= LINE_IDLE;
                    if (load) begin
                        state     <= START;
                        shift_reg <= fifo_head;
                        n_bits    <= frame_bits(tx_bits);
                    end
                end
                START: begin
                    tx      <= LINE_START;
                    state   <= DATA;
                    bit_cnt <= '0;
                end
                DATA: begin
                    tx        <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    if (bit_cnt == n_bits - CNT_W'(1)) state <= STOP;
                    else                               bit_cnt <= bit_cnt + CNT_W'(1);
                end
                STOP: begin
                    tx        <= LINE_STOP;
                    state     <= GUARD;
                    guard_cnt <= '0;
                end
                GUARD: begin
                    tx <= LINE_IDLE;
                    if (guard_last) begin
                        if (load) begin
                            state     <= START;
                            shift_reg <= fifo_head;
                            n_bits    <= frame_bits(tx_bits);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        guard_cnt <= guard_cnt + GRD_W'(1);
                    end
                end
                default: begin
                    tx    <= LINE_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a frame monitor decodes the line and pops a
// scoreboard of words queued by the stimulus.
module tb_uart_tx;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int GUARD = 1;

    typedef struct {
        logic [7:0] data;
        int         n;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [5:0] tx_bits;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_level;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    bit   mon_en   = 1'b0;
    bit   mon_busy = 1'b0;
    exp_t sb[$];
    int   start_q[$];

    uart_tx #(
        .MAX_WORD_SIZE (W),
        .FIFO_DEPTH    (DEPTH),
        .GUARD_CYCLES  (GUARD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .tx_bits    (tx_bits),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish before 10000 cycles");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [7:0] d, input int n);
        exp_t e;
        e.data = d;
        e.n    = n;
        sb.push_back(e);
    endtask

    // Offers a word from the negedge until accepted; returns the accept cycle.
    task automatic push_word(input logic [7:0] d, output int acc_cyc, output bit ok, output int waited);
        int k = 0;
        @(negedge clk);
        din       = d;
        din_valid = 1'b1;
        while (!din_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        ok     = din_ready;
        waited = k;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        din_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((sb.size() != 0 || mon_busy || tx_busy === 1'b1 || fifo_level != 0) && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, 32'(k < 400), 32'd1);
    endtask

    // Frame monitor acting as the loopback receiver.
    initial begin
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                start_q.push_back(cyc);
                check("busy_at_start", 32'(tx_busy), 32'd1);
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) e = sb.pop_front();
                else begin
                    e.data = 8'h00;
                    e.n    = 8;
                end
                got = '0;
                for (int i = 0; i < e.n; i++) begin
                    @(posedge clk);
                    #1;
                    got[i] = tx;
                end
                check("frame_data", 32'(got), 32'(e.data));
                @(posedge clk);
                #1;
                check("stop_bit", 32'(tx), 32'd1);
                for (int g = 0; g < GUARD; g++) begin
                    @(posedge clk);
                    #1;
                    check("guard_bit", 32'(tx), 32'd1);
                    check("busy_in_guard", 32'(tx_busy), 32'd1);
                    if (g == 0) check("done_in_guard", 32'(tx_done), 32'd1);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int  t;
        int  k;
        int  d0;
        bit  ok;
        bit  bad;

        rst_n     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        tx_bits   = 6'd8;

        // Reset values appear asynchronously, before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("ready_in_reset", 32'(din_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(din_ready), 32'd0);
        @(posedge clk);
        #1 check("ready_after_edge", 32'(din_ready), 32'd1);

        // Single 0xA5 frame and push-to-start latency.
        mon_en = 1'b1;
        start_q.delete();
        d0 = done_cnt;
        expect_word(8'hA5, 8);
        push_word(8'hA5, t, ok, k);
        check("a5_accepted", 32'(ok), 32'd1);
        wait_drain("a5_drain");
        check("a5_frames", 32'(start_q.size()), 32'd1);
        if (start_q.size() != 0) check("a5_latency", 32'(start_q[0] - t), 32'd2);
        check("a5_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Three back-to-back frames.
        start_q.delete();
        d0 = done_cnt;
        expect_word(8'h00, 8);
        expect_word(8'hFF, 8);
        expect_word(8'h3C, 8);
        push_word(8'h00, t, ok, k);
        push_word(8'hFF, t, ok, k);
        push_word(8'h3C, t, ok, k);
        wait_drain("b2b_drain");
        check("b2b_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            check("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'd11);
            check("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'd11);
        end
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd3);

        // Fill the buffer while a frame is in flight.
        expect_word(8'h11, 8);
        push_word(8'h11, t, ok, k);
        k = 0;
        while (tx_busy !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("fill_busy_seen", 32'(tx_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            expect_word(8'h21 + 8'(i), 8);
            push_word(8'h21 + 8'(i), t, ok, k);
        end
        @(negedge clk);
        check("fill_level_full", 32'(fifo_level), 32'd4);
        check("fill_ready_low", 32'(din_ready), 32'd0);
        expect_word(8'h25, 8);
        push_word(8'h25, t, ok, k);
        check("fill_w5_accepted", 32'(ok), 32'd1);
        check("fill_w5_waited", 32'(k > 0), 32'd1);
        check("fill_level_after", 32'(fifo_level), 32'd4);
        wait_drain("fill_drain");

        // Word length latched at frame start; 0 and oversize select 8 bits.
        tx_bits = 6'd5;
        expect_word(8'h1F, 5);
        push_word(8'h1F, t, ok, k);
        repeat (3) @(posedge clk);
        tx_bits = 6'd0;
        expect_word(8'hAA, 8);
        push_word(8'hAA, t, ok, k);
        wait_drain("len_drain");
        tx_bits = 6'd63;
        expect_word(8'h81, 8);
        push_word(8'h81, t, ok, k);
        wait_drain("len_big_drain");
        tx_bits = 6'd8;

        // Push coinciding with the guard-end pop at level 2.
        start_q.delete();
        expect_word(8'hFF, 8);
        push_word(8'hFF, t, ok, k);
        expect_word(8'h5A, 8);
        push_word(8'h5A, d0, ok, k);
        expect_word(8'hC3, 8);
        push_word(8'hC3, d0, ok, k);
        while (cyc < t + 11) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("pp_level_before", 32'(fifo_level), 32'd2);
        check("pp_ready", 32'(din_ready), 32'd1);
        din       = 8'h96;
        din_valid = 1'b1;
        expect_word(8'h96, 8);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        check("pp_level_after", 32'(fifo_level), 32'd2);
        wait_drain("pp_drain");
        check("pp_frames", 32'(start_q.size()), 32'd4);
        if (start_q.size() == 4) check("pp_gap", 32'(start_q[1] - start_q[0]), 32'd11);

        // Reset mid-DATA with words still queued.
        mon_en = 1'b0;
        push_word(8'h55, t, ok, k);
        push_word(8'h66, d0, ok, k);
        push_word(8'h77, d0, ok, k);
        while (cyc < t + 4) begin
            @(posedge clk);
            #1;
        end
        check("mid_tx_low", 32'(tx), 32'd0);
        check("mid_level", 32'(fifo_level), 32'd2);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_done", 32'(tx_done), 32'd0);
        check("mid_rst_ready", 32'(din_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);
        check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("post_rst_level", 32'(fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter MAX_WORD_SIZE, default 8: maximum data bits per frame; dout/din width.
REQ-002 Parameter FIFO_DEPTH, default 4: input buffer depth in words; power of 2, ≥2.
REQ-003 Parameter GUARD_CYCLES, default 1: idle-high cycles after each stop bit; ≥1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 din  input  MAX_WORD_SIZE  word to transmit, LSB first.
REQ-007 din_valid  input  1  din holds a word to enqueue.
REQ-008 din_ready  output  1  buffer can accept; transfer on din_valid && din_ready at a clk edge.
REQ-009 tx_bits  input  6  data bits per frame, sampled at frame start.
REQ-010 tx  output  1  serial line, one bit per clk, idle high; registered.
REQ-011 tx_busy  output  1  high from START through the last GUARD cycle.
REQ-012 tx_done  output  1  one-cycle pulse per completed frame.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

Function
REQ-014 Frame on tx: one start bit (0), N data bits LSB first, one stop bit (1), GUARD_CYCLES high; each bit exactly one clk cycle.
REQ-015 N = tx_bits latched at IDLE->START; tx_bits 0 or >MAX_WORD_SIZE SHALL be treated as MAX_WORD_SIZE; later tx_bits changes do not affect the frame in flight.
REQ-016 States: IDLE, START, DATA, STOP, GUARD.
REQ-017 IDLE: tx=1; if FIFO non-empty -> START, pop head word into shift register, latch N.
REQ-018 START: tx=0 for 1 cycle -> DATA.
REQ-019 DATA: tx = shift_reg[0], shift right each cycle, bit counter 0..N-1; at count N-1 -> STOP.
REQ-020 STOP: tx=1 for 1 cycle -> GUARD.
REQ-021 GUARD: tx=1 for GUARD_CYCLES cycles; on last cycle, FIFO non-empty -> START (with pop, latch as REQ-017), else -> IDLE.
REQ-022 Back-to-back frame period with GUARD_CYCLES=1: N+3 cycles; this gap matches the receiver's DONE recovery cycle.
REQ-023 tx_done SHALL be high exactly during the first GUARD cycle of each frame.
REQ-024 Latency: word accepted at edge t into empty FIFO with FSM in IDLE -> tx falls at edge t+2.
REQ-025 din_ready = !full; push when full ignored (din_ready low); push and pop in same cycle SHALL both occur, level unchanged.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH exactly.
REQ-027 Word popped only on transition into START; no other consumption.

Reset
REQ-028 On rst_n low, immediately: tx=1, state=IDLE, tx_busy=0, tx_done=0, FIFO emptied (fifo_level=0), din_ready=0.
REQ-029 din_ready=1 from first clk edge after rst_n deasserts.
REQ-030 Reset mid-frame SHALL abort the frame, discard buffered words, and release tx high with no glitch low.

Structure
REQ-031 Shared package uart_pkg: state enum, default MAX_WORD_SIZE, stop/idle line level constants.
REQ-032 Sub-module uart_tx_fifo: synchronous FIFO (push/pop/full/empty/level), instantiated once.

Verification
REQ-033 N=8, push 0xA5 into idle block -> tx from edge t+2: 0,1,0,1,0,0,1,0,1,1(stop),1(guard); tx_done once in guard cycle.
REQ-034 N=8, push 0x00,0xFF,0x3C back-to-back -> three frames, start bits 11 cycles apart, 3 tx_done pulses; loopback to uart_rx yields same 3 words.
REQ-035 Push 5 words with FIFO_DEPTH=4 while FSM busy -> din_ready low after 4th buffered word, fifo_level=4, 5th accepted only after pop.
REQ-036 tx_bits=5, word 0x1F then tx_bits=0 with 0xAA -> first frame 5 data bits all 1; second frame 8 data bits 0,1,0,1,0,1,0,1.
REQ-037 rst_n low mid DATA of 0x55 with 2 words queued -> tx=1 immediately, fifo_level=0, no tx_done; no frame emitted after release.
REQ-038 Simultaneous push and pop at fifo_level=2 -> fifo_level stays 2, word order preserved on tx.
